// File: rtl/hash_bit_serializer.sv
// Byte-to-bit feeder for the bit-serial hash core: a small FIFO of bytes
// followed by a shifter that emits each byte MSB-first, one bit per clock.
`timescale 1ns/1ps
module hash_bit_serializer #(
    parameter int DEPTH    = 4,
    parameter int GAP      = 0,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic [7:0]               io_in_bits,
    output logic                     io_out,
    output logic                     io_out_valid,
    output logic                     io_byte_start,
    output logic [$clog2(DEPTH):0]   io_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          running;
    logic [1:0]    state;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    logic [7:0]    gap_cnt;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // running keeps ready low while reset is held and until the first edge after release
    assign io_in_ready = running && (count < FULL_COUNT);
    assign push        = io_in_valid && io_in_ready;
    assign head        = mem[rd_ptr];
    assign io_count    = count;

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = (count != '0);
            ST_SHIFT: pop = (idx == 3'd7) && (GAP == 0) && (count != '0);
            ST_GAP:   pop = (gap_cnt == 8'd1) && (count != '0);
            default:  pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= io_in_bits;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A pop always wins: it reloads the shifter and presents the new MSB on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            idx           <= '0;
            gap_cnt       <= '0;
            io_out        <= IDLE_BIT;
            io_out_valid  <= 1'b0;
            io_byte_start <= 1'b0;
        end else begin
            io_byte_start <= 1'b0;
            if (pop) begin
                state         <= ST_SHIFT;
                shreg         <= head;
                idx           <= 3'd0;
                io_out        <= head[7];
                io_out_valid  <= 1'b1;
                io_byte_start <= 1'b1;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (idx != 3'd7) begin
                            idx    <= idx + 3'd1;
                            io_out <= shreg[3'd6 - idx];
                        end else begin
                            io_out       <= IDLE_BIT;
                            io_out_valid <= 1'b0;
                            if (GAP > 0) begin
                                state   <= ST_GAP;
                                gap_cnt <= 8'(GAP);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == 8'd1) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state        <= ST_IDLE;
                        io_out       <= IDLE_BIT;
                        io_out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hash_bit_serializer.sv
// Scoreboard bench for hash_bit_serializer: one instance with GAP=0/IDLE_BIT=0,
// a second with GAP=2/IDLE_BIT=1 for the inter-byte gap behaviour.
`timescale 1ns/1ps
module tb_hash_bit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       v0, rdy0, out0, ov0, bs0;
    logic [7:0] bits0;
    logic [2:0] cnt0;
    logic       v1, rdy1, out1, ov1, bs1;
    logic [7:0] bits1;
    logic [2:0] cnt1;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic b;
        logic s;
    } exp_t;

    exp_t sb[$];

    hash_bit_serializer #(.DEPTH(4), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .io_in_valid(v0), .io_in_ready(rdy0), .io_in_bits(bits0),
        .io_out(out0), .io_out_valid(ov0), .io_byte_start(bs0), .io_count(cnt0)
    );

    hash_bit_serializer #(.DEPTH(4), .GAP(2), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .io_in_valid(v1), .io_in_ready(rdy1), .io_in_bits(bits1),
        .io_out(out1), .io_out_valid(ov1), .io_byte_start(bs1), .io_count(cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] v);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            e.b = v[i];
            e.s = (i == 7);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        v0 = 1'b0; bits0 = 8'h00;
        v1 = 1'b0; bits1 = 8'h00;
        tick;
        tick;
        n_compared++; if (ov0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid0: got %b want 0", ov0); end
        n_compared++; if (out0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out0: got %b want 0", out0); end
        n_compared++; if (bs0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_start0: got %b want 0", bs0); end
        n_compared++; if (rdy0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ready0: got %b want 0", rdy0); end
        n_compared++; if (cnt0 !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_count0: got %0d want 0", cnt0); end
        n_compared++; if (out1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_out1_idlebit: got %b want 1", out1); end
        n_compared++; if (rdy1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ready1: got %b want 0", rdy1); end
        reset = 1'b1;
        tick;
        n_compared++; if (rdy0 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_ready0: got %b want 1", rdy0); end
        n_compared++; if (rdy1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_ready1: got %b want 1", rdy1); end
    endtask

    task automatic test_single;
        exp_t e;
        sb.delete();
        bits0 = 8'hA5; v0 = 1'b1;
        tick;
        push_exp(8'hA5);
        v0 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            n_compared++; if (ov0 !== (k <= 8)) begin n_mismatched++; $display("[TB] FAIL single_valid[%0d]: got %b want %b", k, ov0, (k <= 8)); end
            if (k <= 8) begin
                e = sb.pop_front();
                n_compared++; if (out0 !== e.b) begin n_mismatched++; $display("[TB] FAIL single_bit[%0d]: got %b want %b", k, out0, e.b); end
                n_compared++; if (bs0 !== e.s) begin n_mismatched++; $display("[TB] FAIL single_start[%0d]: got %b want %b", k, bs0, e.s); end
            end else begin
                n_compared++; if (out0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_idle[%0d]: got %b want 0", k, out0); end
            end
        end
        n_compared++; if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL single_drain: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        sb.delete();
        bits0 = 8'hFF; v0 = 1'b1;
        tick;
        push_exp(8'hFF);
        bits0 = 8'h00;
        tick;
        push_exp(8'h00);
        v0 = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) tick;
            n_compared++; if (ov0 !== (k <= 16)) begin n_mismatched++; $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", k, ov0, (k <= 16)); end
            if (k <= 16) begin
                e = sb.pop_front();
                n_compared++; if (out0 !== e.b) begin n_mismatched++; $display("[TB] FAIL b2b_bit[%0d]: got %b want %b", k, out0, e.b); end
                n_compared++; if (bs0 !== e.s) begin n_mismatched++; $display("[TB] FAIL b2b_start[%0d]: got %b want %b", k, bs0, e.s); end
            end
        end
        n_compared++; if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL b2b_drain: got %0d left want 0", sb.size()); end
    endtask

    // Valid stays high through the full window; bytes offered while not ready are junk
    task automatic test_fill_and_hold;
        exp_t e;
        logic exp_rdy;
        logic acc;
        logic expv;
        logic [7:0] nxt;
        sb.delete();
        exp_rdy = 1'b1;
        nxt = 8'h01;
        bits0 = nxt; v0 = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            acc = v0 && exp_rdy;
            tick;
            if (acc) begin
                push_exp(bits0);
                nxt = nxt + 8'd1;
            end
            exp_rdy = !(k >= 4 && k <= 8);
            n_compared++; if (rdy0 !== exp_rdy) begin n_mismatched++; $display("[TB] FAIL fill_ready[%0d]: got %b want %b", k, rdy0, exp_rdy); end
            if (k == 4) begin
                n_compared++; if (cnt0 !== 3'd4) begin n_mismatched++; $display("[TB] FAIL fill_count: got %0d want 4", cnt0); end
            end
            expv = (k >= 1 && k <= 40);
            n_compared++; if (ov0 !== expv) begin n_mismatched++; $display("[TB] FAIL fill_valid[%0d]: got %b want %b", k, ov0, expv); end
            if (expv && sb.size() == 0) begin
                n_compared++; n_mismatched++;
                $display("[TB] FAIL fill_underrun[%0d]: got empty scoreboard want a bit", k);
            end else if (expv) begin
                e = sb.pop_front();
                n_compared++; if (out0 !== e.b) begin n_mismatched++; $display("[TB] FAIL fill_bit[%0d]: got %b want %b", k, out0, e.b); end
                n_compared++; if (bs0 !== e.s) begin n_mismatched++; $display("[TB] FAIL fill_start[%0d]: got %b want %b", k, bs0, e.s); end
            end
            v0 = (k < 9);
            bits0 = exp_rdy ? nxt : (8'hE0 + 8'(k));
        end
        v0 = 1'b0;
        n_compared++; if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL fill_drain: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_gap;
        exp_t e;
        logic expv;
        sb.delete();
        bits1 = 8'h80; v1 = 1'b1;
        tick;
        push_exp(8'h80);
        bits1 = 8'h01;
        tick;
        push_exp(8'h01);
        v1 = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k > 1) tick;
            expv = (k <= 8) || (k >= 11 && k <= 18);
            n_compared++; if (ov1 !== expv) begin n_mismatched++; $display("[TB] FAIL gap_valid[%0d]: got %b want %b", k, ov1, expv); end
            if (expv) begin
                e = sb.pop_front();
                n_compared++; if (out1 !== e.b) begin n_mismatched++; $display("[TB] FAIL gap_bit[%0d]: got %b want %b", k, out1, e.b); end
                n_compared++; if (bs1 !== e.s) begin n_mismatched++; $display("[TB] FAIL gap_start[%0d]: got %b want %b", k, bs1, e.s); end
            end else begin
                n_compared++; if (out1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL gap_idlebit[%0d]: got %b want 1", k, out1); end
            end
        end
        n_compared++; if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL gap_drain: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_mid_byte;
        exp_t e;
        sb.delete();
        bits0 = 8'hC3; v0 = 1'b1;
        tick;
        bits0 = 8'h11;
        tick;
        bits0 = 8'h22;
        tick;
        v0 = 1'b0;
        tick;
        tick;
        n_compared++; if (ov0 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_valid: got %b want 1", ov0); end
        n_compared++; if (out0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_bit3: got %b want 0", out0); end
        n_compared++; if (cnt0 !== 3'd2) begin n_mismatched++; $display("[TB] FAIL mid_count: got %0d want 2", cnt0); end
        #2 reset = 1'b0;
        #1;
        n_compared++; if (ov0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_valid: got %b want 0", ov0); end
        n_compared++; if (out0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_out: got %b want 0", out0); end
        n_compared++; if (bs0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_start: got %b want 0", bs0); end
        n_compared++; if (cnt0 !== 3'd0) begin n_mismatched++; $display("[TB] FAIL async_count: got %0d want 0", cnt0); end
        n_compared++; if (rdy0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_ready: got %b want 0", rdy0); end
        tick;
        tick;
        reset = 1'b1;
        tick;
        n_compared++; if (rdy0 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rerelease_ready: got %b want 1", rdy0); end
        for (int k = 0; k < 10; k++) begin
            tick;
            n_compared++; if (ov0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stale_valid[%0d]: got %b want 0", k, ov0); end
        end
        bits0 = 8'h5A; v0 = 1'b1;
        tick;
        push_exp(8'h5A);
        v0 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick;
            n_compared++; if (ov0 !== (k <= 8)) begin n_mismatched++; $display("[TB] FAIL post_valid[%0d]: got %b want %b", k, ov0, (k <= 8)); end
            if (k <= 8) begin
                e = sb.pop_front();
                n_compared++; if (out0 !== e.b) begin n_mismatched++; $display("[TB] FAIL post_bit[%0d]: got %b want %b", k, out0, e.b); end
                n_compared++; if (bs0 !== e.s) begin n_mismatched++; $display("[TB] FAIL post_start[%0d]: got %b want %b", k, bs0, e.s); end
            end
        end
        n_compared++; if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL post_drain: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_fill_and_hold;
        test_gap;
        test_reset_mid_byte;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
